// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// The state encoding is visible on the debug port, so its values are fixed.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  // Defaults assume the 25 MHz board reference clock.
  localparam int unsigned DEF_CHANNELS    = 3;
  localparam int unsigned DEF_LOCK_STABLE = 1024;
  localparam int unsigned DEF_STAGGER     = 16;
  localparam int unsigned DEF_TIMEOUT     = 250000;
  localparam int unsigned DEF_RST_PULSE   = 32;
  localparam int unsigned DEF_CNT_W       = 8;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock flag into the reference clock domain.
module pll_lock_sync (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  output logic locked_s
);

  logic meta;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      meta     <= locked;
      locked_s <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises an EHXPLLL lock output and sequences staggered per-domain resets.
// Define PLL_RESEQ_STATS_EN to build the lock-loss and retry counters.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEF_CHANNELS,
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int unsigned STAGGER     = DEF_STAGGER,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned RST_PULSE   = DEF_RST_PULSE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                locked,
  input  logic                sw_restart,
  output logic                pll_rst,
  output logic [CHANNELS-1:0] chan_reset,
  output logic                ready,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    lock_losses,
  output logic [CNT_W-1:0]    retries
);

  localparam int unsigned TIMER_W =
    $clog2(max_of4(TIMEOUT, LOCK_STABLE, RST_PULSE, CHANNELS * STAGGER)) + 1;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
  localparam logic [TIMER_W-1:0] RELEASE_END  = TIMER_W'(CHANNELS * STAGGER);

  seq_state_t           cur, nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [CHANNELS-1:0]  chan_nxt;
  logic                 locked_s;
  logic                 loss_evt, retry_evt;

  pll_lock_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .locked_s (locked_s)
  );

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    nxt       = cur;
    timer_nxt = timer + 1'b1;
    loss_evt  = 1'b0;
    retry_evt = 1'b0;
    unique case (cur)
      RESET_PLL: if (timer == RST_LAST) begin
        nxt       = WAIT_LOCK;
        timer_nxt = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        nxt       = STABLE;
        timer_nxt = '0;
      end else if (timer == TIMEOUT_LAST) begin
        nxt       = RESET_PLL;
        timer_nxt = '0;
        retry_evt = 1'b1;
      end
      STABLE: if (!locked_s) begin
        nxt       = WAIT_LOCK;
        timer_nxt = '0;
      end else if (timer == STABLE_LAST) begin
        nxt       = RELEASE;
        timer_nxt = '0;
      end
      RELEASE: if (!locked_s) begin
        nxt       = WAIT_LOCK;
        timer_nxt = '0;
        loss_evt  = 1'b1;
      end else if (timer == RELEASE_END) begin
        nxt       = RUN;
        timer_nxt = '0;
      end
      RUN: begin
        timer_nxt = '0;
        if (!locked_s) begin
          nxt      = WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      default: begin
        nxt       = RESET_PLL;
        timer_nxt = '0;
      end
    endcase

    // A software restart overrides whatever the lock monitor decided this cycle.
    if (sw_restart && cur != RESET_PLL) begin
      nxt       = RESET_PLL;
      timer_nxt = '0;
      loss_evt  = 1'b0;
      retry_evt = 1'b0;
    end
  end

  // Release only ever clears bits of the current mask, so ordering cannot invert.
  always_comb begin
    chan_nxt = '1;
    unique case (nxt)
      RELEASE: begin
        chan_nxt = (cur == RELEASE) ? chan_reset : '1;
        for (int k = 0; k < int'(CHANNELS); k++) begin
          if (cur == RELEASE && int'(timer) == (k + 1) * int'(STAGGER) - 1)
            chan_nxt[k] = 1'b0;
        end
      end
      RUN:     chan_nxt = '0;
      default: chan_nxt = '1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= RESET_PLL;
      timer      <= '0;
      pll_rst    <= 1'b1;
      chan_reset <= '1;
      ready      <= 1'b0;
    end else begin
      cur        <= nxt;
      timer      <= timer_nxt;
      pll_rst    <= (nxt == RESET_PLL);
      chan_reset <= chan_nxt;
      ready      <= (nxt == RUN);
    end
  end

  assign state = cur;

`ifdef PLL_RESEQ_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_losses <= '0;
      retries     <= '0;
    end else begin
      if (loss_evt && !(&lock_losses)) lock_losses <= lock_losses + 1'b1;
      if (retry_evt && !(&retries))    retries     <= retries + 1'b1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = loss_evt | retry_evt;
  assign lock_losses  = '0;
  assign retries      = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised scoreboard bench for pll_reset_sequencer; expected output changes are
// derived from elapsed-time rules and checked by an independent monitor.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  localparam int CHANNELS    = 3;
  localparam int LOCK_STABLE = 8;
  localparam int STAGGER     = 4;
  localparam int TIMEOUT     = 64;
  localparam int RST_PULSE   = 4;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PLL_RESEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                locked;
  logic                sw_restart;
  logic                pll_rst;
  logic [CHANNELS-1:0] chan_reset;
  logic                ready;
  logic [2:0]          state;
  logic [CNT_W-1:0]    lock_losses;
  logic [CNT_W-1:0]    retries;

  pll_reset_sequencer #(
    .CHANNELS(CHANNELS), .LOCK_STABLE(LOCK_STABLE), .STAGGER(STAGGER),
    .TIMEOUT(TIMEOUT), .RST_PULSE(RST_PULSE), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .locked(locked), .sw_restart(sw_restart),
    .pll_rst(pll_rst), .chan_reset(chan_reset), .ready(ready), .state(state),
    .lock_losses(lock_losses), .retries(retries)
  );

  always #20 clock = ~clock;

  typedef struct packed {
    logic                pll_rst;
    logic [CHANNELS-1:0] chan;
    logic                ready;
    logic [2:0]          st;
    logic [CNT_W-1:0]    losses;
    logic [CNT_W-1:0]    retries;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t val;
  } evt_t;

  evt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference model: a phase plus the edge at which it was entered.
  seq_state_t m_phase;
  int         m_start;
  int         m_losses, m_retries;
  logic       m_s1, m_s2;
  obs_t       m_last;

  function automatic obs_t model_obs();
    obs_t o;
    int   d;
    d         = cyc - m_start;
    o.pll_rst = (m_phase == RESET_PLL);
    o.ready   = (m_phase == RUN);
    o.st      = m_phase;
    o.chan    = '1;
    for (int k = 0; k < CHANNELS; k++)
      if (m_phase == RUN || (m_phase == RELEASE && d >= (k + 1) * STAGGER)) o.chan[k] = 1'b0;
    o.losses  = STATS ? CNT_W'(m_losses)  : '0;
    o.retries = STATS ? CNT_W'(m_retries) : '0;
    return o;
  endfunction

  function automatic void enter(input seq_state_t p);
    m_phase = p;
    m_start = cyc;
  endfunction

  function automatic void model_edge(input logic lk, input logic sw);
    logic ls;
    int   d;
    obs_t o;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    d    = cyc - m_start;
    if (sw && m_phase != RESET_PLL) enter(RESET_PLL);
    else begin
      case (m_phase)
        RESET_PLL: if (d == RST_PULSE) enter(WAIT_LOCK);
        WAIT_LOCK: if (ls) enter(STABLE);
                   else if (d == TIMEOUT) begin
                     enter(RESET_PLL);
                     if (m_retries < CNT_MAX) m_retries++;
                   end
        STABLE:    if (!ls) enter(WAIT_LOCK);
                   else if (d == LOCK_STABLE) enter(RELEASE);
        default: begin
          if (!ls) begin
            enter(WAIT_LOCK);
            if (m_losses < CNT_MAX) m_losses++;
          end else if (m_phase == RELEASE && d == CHANNELS * STAGGER + 1) enter(RUN);
        end
      endcase
    end
    o = model_obs();
    if (o != m_last) exp_q.push_back('{cyc, o});
    m_last = o;
  endfunction

  // Called at a falling edge; drives inputs, lets one rising edge pass, returns at the next fall.
  task automatic step(input logic lk, input logic sw);
    locked     = lk;
    sw_restart = sw;
    @(posedge clock);
    cyc++;
    model_edge(lk, sw);
    @(negedge clock);
  endtask

  task automatic run(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  obs_t mon_cur, mon_last;
  evt_t mon_e;

  always @(negedge clock) begin
    if (mon_en) begin
      mon_cur = {pll_rst, chan_reset, ready, state, lock_losses, retries};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_change at cycle %0d: outputs stayed %0h, expected %0h from cycle %0d",
                 cyc, mon_cur, exp_q[0].val, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (mon_cur != mon_last) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          mon_e = exp_q.pop_front();
          check("output_change", mon_cur, mon_e.val);
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change at cycle %0d: got %0h, expected %0h",
                   cyc, mon_cur, mon_last);
        end
        mon_last = mon_cur;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},     pll_rst,     1'b1);
    check({tag, "_chan_reset"},  chan_reset,  {CHANNELS{1'b1}});
    check({tag, "_ready"},       ready,       1'b0);
    check({tag, "_state"},       state,       RESET_PLL);
    check({tag, "_lock_losses"}, lock_losses, '0);
    check({tag, "_retries"},     retries,     '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk, len, sel;
    reset      = 1'b1;
    locked     = 1'b1;
    sw_restart = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");

    m_phase   = RESET_PLL;
    m_start   = 0;
    m_losses  = 0;
    m_retries = 0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
    cyc       = 0;
    m_last    = model_obs();
    mon_last  = m_last;
    reset     = 1'b0;
    mon_en    = 1'b1;

    // Lock present from reset: straight through to RUN.
    run(1'b1, 40);
    // Lock loss in RUN, then relock.
    run(1'b0, 3);
    run(1'b1, 40);
    // Software restart, then a one-cycle glitch after five stable cycles.
    step(1'b1, 1'b1);
    run(1'b1, 4 + 2 + 5);
    run(1'b0, 1);
    run(1'b1, 40);
    // Restart coinciding with the synchronised lock falling in RUN.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run(1'b1, 40);
    // No lock: watchdog retries until the counter saturates.
    run(1'b0, 4 * (RST_PULSE + TIMEOUT) + 20);
    run(1'b1, 40);

    for (int s = 0; s < 40; s++) begin
      lk  = $urandom_range(0, 1);
      sel = $urandom_range(0, 2);
      len = (sel == 0) ? $urandom_range(1, 3)
          : (sel == 1) ? $urandom_range(5, 15) : $urandom_range(20, 80);
      step(lk[0], ($urandom_range(0, 7) == 0));
      run(lk[0], len - 1);
    end
    run(1'b1, 30);
    #1;
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset between clock edges.
    mon_en = 1'b0;
    #7;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
